// File: rtl/ipif_register_master.sv
// IPIF bus initiator: converts single register read/write commands into IPIF
// bus2ip cycles with one-hot CE, waits for ack (bounded) and returns a response.
module ipif_register_master #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned N_REG              = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_status,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] IPIF_bus2ip_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] IPIF_bus2ip_data,
  output logic [N_REG-1:0]              IPIF_bus2ip_rdce,
  output logic [N_REG-1:0]              IPIF_bus2ip_wrce,
  output logic                          IPIF_bus2ip_resetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] IPIF_ip2bus_data,
  input  logic                          IPIF_ip2bus_rdack,
  input  logic                          IPIF_ip2bus_wrack
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADADDR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, RESP} state_e;

  state_e           state_q,      state_d;
  logic             cmd_ready_q,  cmd_ready_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q,  rsp_rdata_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [AW-1:0]    addr_q,       addr_d;
  logic [DW-1:0]    data_q,       data_d;
  logic [N_REG-1:0] rdce_q,       rdce_d;
  logic [N_REG-1:0] wrce_q,       wrce_d;
  logic             resetn_q,     resetn_d;
  logic             is_write_q,   is_write_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic [N_REG-1:0] ce_sel;
  logic             ack;

  assign ce_sel = N_REG'(1) << cmd_addr;
  assign ack    = is_write_q ? IPIF_ip2bus_wrack : IPIF_ip2bus_rdack;

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rdce_d       = rdce_q;
    wrce_d       = wrce_q;
    resetn_d     = 1'b1;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          is_write_d  = cmd_write;
          if (cmd_addr >= AW'(N_REG)) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_BADADDR;
            rsp_rdata_d  = '0;
          end else begin
            state_d = ACCESS;
            addr_d  = cmd_addr;
            data_d  = cmd_write ? cmd_wdata : '0;
            cnt_d   = '0;
            if (cmd_write) wrce_d = ce_sel;
            else           rdce_d = ce_sel;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      // Matching ack is checked before the timeout so a same-cycle ack wins.
      ACCESS: begin
        if (ack || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d      = RECOVER;
          rdce_d       = '0;
          wrce_d       = '0;
          addr_d       = '0;
          data_d       = '0;
          rsp_status_d = ack ? ST_OK : ST_TIMEOUT;
          rsp_rdata_d  = (ack && !is_write_q) ? IPIF_ip2bus_data : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      addr_q       <= '0;
      data_q       <= '0;
      rdce_q       <= '0;
      wrce_q       <= '0;
      resetn_q     <= 1'b0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdce_q       <= rdce_d;
      wrce_q       <= wrce_d;
      resetn_q     <= resetn_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_status         = rsp_status_q;
  assign IPIF_bus2ip_addr   = addr_q;
  assign IPIF_bus2ip_data   = data_q;
  assign IPIF_bus2ip_rdce   = rdce_q;
  assign IPIF_bus2ip_wrce   = wrce_q;
  assign IPIF_bus2ip_resetn = resetn_q;

endmodule

// File: tb/tb_ipif_register_master.sv
// Randomized self-checking bench for ipif_register_master with a configurable
// IPIF responder (ack latency, silence, trailing ack, wrong-ack noise).
module tb_ipif_register_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [NR-1:0] rdce, wrce;
  logic          bus_resetn;
  logic [DW-1:0] ip_data;
  logic          ip_rdack, ip_wrack;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ipif_register_master #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .N_REG(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .IPIF_bus2ip_addr(bus_addr), .IPIF_bus2ip_data(bus_data),
    .IPIF_bus2ip_rdce(rdce), .IPIF_bus2ip_wrce(wrce),
    .IPIF_bus2ip_resetn(bus_resetn),
    .IPIF_ip2bus_data(ip_data), .IPIF_ip2bus_rdack(ip_rdack),
    .IPIF_ip2bus_wrack(ip_wrack)
  );

  // Responder: acks once CE has been seen for rsp_lat cycles and keeps acking
  // while CE stays high (so it produces a trailing ack); 0 = silent.
  int      rsp_lat  = 1;
  bit      noise_en = 1'b0;
  int      hold     = 0;
  bit      ack_q, ack_wr_q, noise_rd_q, noise_wr_q;
  bit [DW-1:0] regs [NR];
  bit [DW-1:0] ip_data_q;
  logic        ce_any, ack_now;

  assign ce_any  = (rdce != '0) || (wrce != '0);
  assign ack_now = (rsp_lat != 0) && ce_any && (hold + 1 >= rsp_lat);

  always @(posedge clk) begin
    hold       <= ce_any ? hold + 1 : 0;
    ack_q      <= ack_now;
    ack_wr_q   <= (wrce != '0);
    noise_rd_q <= noise_en && (wrce != '0) && ($urandom_range(0, 1) == 1);
    noise_wr_q <= noise_en && (rdce != '0) && ($urandom_range(0, 1) == 1);
    if (ack_now && wrce != '0) regs[int'(bus_addr) % NR] <= bus_data;
    ip_data_q  <= (ack_now && rdce != '0) ? regs[int'(bus_addr) % NR] : DW'($urandom);
  end

  assign ip_data  = ip_data_q;
  assign ip_rdack = (ack_q && !ack_wr_q) || noise_rd_q;
  assign ip_wrack = (ack_q && ack_wr_q) || noise_wr_q;

  // Reference register contents as seen by a correct initiator.
  bit [DW-1:0] mregs [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int lat, input int hold_cyc, input bit poke);
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_status;
    int            exp_lat, exp_ce, cyc, ce_cnt, k;
    logic [NR-1:0] oh;
    bit            bad, stable;

    if (a >= AW'(NR)) begin
      exp_status = 2'b01; exp_rdata = '0; exp_lat = 1; exp_ce = 0;
    end else if (lat >= 1 && lat <= TO - 1) begin
      exp_status = 2'b00; exp_rdata = wr ? '0 : mregs[a];
      exp_lat = lat + 3; exp_ce = lat + 1;
      if (wr) mregs[a] = wd;
    end else begin
      exp_status = 2'b10; exp_rdata = '0; exp_lat = TO + 2; exp_ce = TO;
    end
    oh = (a < AW'(NR)) ? NR'(1) << a : '0;
    rsp_lat = lat;

    k = 0;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    chk("cmd_ready_before_issue", cmd_ready, 1);

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0; cmd_wdata = DW'($urandom);
    cyc = 1; ce_cnt = 0; bad = 1'b0;
    while (!rsp_valid && cyc < 60) begin
      if (rdce != '0 || wrce != '0) begin
        ce_cnt++;
        if (wr) bad |= (wrce != oh) || (rdce != '0) || (bus_data != wd);
        else    bad |= (rdce != oh) || (wrce != '0) || (bus_data != '0);
        bad |= (bus_addr != a) || cmd_ready;
      end
      tick();
      cyc++;
    end
    chk("rsp_latency", 64'(cyc), 64'(exp_lat));
    chk("ce_cycles", 64'(ce_cnt), 64'(exp_ce));
    chk("ce_pattern_ok", 64'(bad), 64'(0));
    chk("rsp_status", 64'(rsp_status), 64'(exp_status));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));

    stable = 1'b1;
    for (int i = 0; i < hold_cyc; i++) begin
      if (poke) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = AW'($urandom_range(0, 1));
      end
      tick();
      stable &= rsp_valid && (rsp_rdata == exp_rdata) && (rsp_status == exp_status) &&
                !cmd_ready && (rdce == '0) && (wrce == '0);
    end
    cmd_valid = 1'b0;
    if (hold_cyc > 0) chk("rsp_held_stable", 64'(stable), 64'(1));

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int lats [9] = '{0, 1, 2, 3, 7, 14, 15, 16, 17};
    logic [AW-1:0] ra;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_resetn", 64'(bus_resetn), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_ce", 64'({rdce, wrce}), 64'(0));
    chk("rst_addr_data", 64'({bus_addr, bus_data}), 64'(0));
    chk("rst_rsp", 64'({rsp_status, rsp_rdata}), 64'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("post_rst_resetn", 64'(bus_resetn), 64'(1));

    txn(1'b1, 0, 32'h1234_5678, 1, 0, 1'b0);
    txn(1'b1, 1, 32'hDEAD_BEEF, 1, 0, 1'b0);
    chk("resp_reg1", 64'(regs[1]), 64'h0000_0000_DEAD_BEEF);
    txn(1'b0, 0, '0, 1, 0, 1'b0);
    txn(1'b0, 1, '0, 1, 0, 1'b0);
    txn(1'b0, 1, '0, 0, 0, 1'b0);
    txn(1'b0, 5, '0, 1, 0, 1'b0);
    txn(1'b1, 5, 32'hFFFF_FFFF, 1, 0, 1'b0);
    txn(1'b1, 0, 32'hA5A5_0F0F, 2, 10, 1'b1);
    txn(1'b0, 0, '0, 15, 0, 1'b0);
    txn(1'b0, 1, '0, 16, 0, 1'b0);

    // Reset in the middle of an access drops the command.
    rsp_lat = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre_reset_rdce", 64'(rdce), 64'(2));
    reset = 1'b1;
    tick();
    chk("mid_rst_ce", 64'({rdce, wrce}), 64'(0));
    chk("mid_rst_resetn", 64'(bus_resetn), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    tick();
    chk("mid_rst_release_ready", 64'(cmd_ready), 64'(1));
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    txn(1'b1, 1, 32'h0BAD_F00D, 1, 0, 1'b0);
    txn(1'b0, 1, '0, 3, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      noise_en = 1'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 2));
      txn(1'($urandom), ra, DW'($urandom), lats[$urandom_range(0, 8)],
          $urandom_range(0, 4), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
